// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced key level to press/release/auto-repeat pulses plus long-press level.
// Optional press counter on CNT when KEYEVT_CNT_EN is defined; otherwise CNT is tied to zero.
module key_event_gen #(
  parameter int LONG_CYC = 1000,
  parameter int REP_CYC  = 200,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KIN,
  output logic       PRESS,
  output logic       RELEASE,
  output logic       REPT,
  output logic       LONG,
  output logic [7:0] CNT
);

  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;

  localparam logic [15:0] LONG_LAST = 16'(LONG_CYC - 1);
  localparam logic [15:0] REP_LAST  = 16'(REP_CYC - 1);

  state_t      state;
  logic        pk;
  logic        k_q;
  logic        armed;
  logic [15:0] timer;
  logic        press_now;

  assign pk        = ACT_LOW ? ~KIN : KIN;
  assign press_now = (state == IDLE) && k_q && armed;

  // k_q resets to "pressed" so a key held through reset must be released before it can fire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      k_q     <= 1'b1;
      armed   <= 1'b0;
      timer   <= 16'd0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      REPT    <= 1'b0;
      LONG    <= 1'b0;
    end else begin
      k_q     <= pk;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      REPT    <= 1'b0;
      if (!k_q) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (press_now) begin
            PRESS <= 1'b1;
            timer <= 16'd0;
            state <= HELD;
          end
        end
        HELD: begin
          // Release is checked first so it wins over a coincident timer match.
          if (!k_q) begin
            RELEASE <= 1'b1;
            timer   <= 16'd0;
            state   <= IDLE;
          end else if (timer == LONG_LAST) begin
            REPT  <= 1'b1;
            LONG  <= 1'b1;
            timer <= 16'd0;
            state <= RPT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RPT: begin
          if (!k_q) begin
            RELEASE <= 1'b1;
            LONG    <= 1'b0;
            timer   <= 16'd0;
            state   <= IDLE;
          end else if (timer == REP_LAST) begin
            REPT  <= 1'b1;
            timer <= 16'd0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          timer <= 16'd0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef KEYEVT_CNT_EN
  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= 8'h00;
    end else if (press_now) begin
      cnt <= cnt + 8'h01;
    end
  end

  assign CNT = cnt;
`else
  assign CNT = 8'h00;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - self-checking bench for key_event_gen against a hold-time reference model.
module tb_key_event_gen;

  localparam int LA = 1000;
  localparam int RA = 200;
  localparam int LB = 10;
  localparam int RB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kin_a = 1'b1;
  logic       kin_b = 1'b0;
  logic       press_a, release_a, rept_a, long_a;
  logic       press_b, release_b, rept_b, long_b;
  logic [7:0] cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  bit       mkq[2];
  bit       marm[2];
  bit       mheld[2];
  int       h[2];
  bit       ep[2], er[2], ert[2], el[2];
  logic [7:0] mcnt[2];

  bit bgen = 1'b0;
  int bleft = 0;

  always #5 clk = ~clk;

  key_event_gen #(.LONG_CYC(LA), .REP_CYC(RA), .ACT_LOW(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .KIN(kin_a),
    .PRESS(press_a), .RELEASE(release_a), .REPT(rept_a), .LONG(long_a), .CNT(cnt_a)
  );

  key_event_gen #(.LONG_CYC(LB), .REP_CYC(RB), .ACT_LOW(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .KIN(kin_b),
    .PRESS(press_b), .RELEASE(release_b), .REPT(rept_b), .LONG(long_b), .CNT(cnt_b)
  );

  function automatic logic [7:0] exp_cnt(input int i);
`ifdef KEYEVT_CNT_EN
    return mcnt[i];
`else
    return 8'h00;
`endif
  endfunction

  // Outputs derived from h = cycles since the PRESS pulse of the current hold.
  task automatic model_step(input int i, input bit pk, input bit r);
    int lc;
    int rc;
    lc = (i == 0) ? LA : LB;
    rc = (i == 0) ? RA : RB;
    ep[i] = 1'b0; er[i] = 1'b0; ert[i] = 1'b0;
    if (r) begin
      el[i] = 1'b0; mkq[i] = 1'b1; marm[i] = 1'b0; mheld[i] = 1'b0; h[i] = 0; mcnt[i] = 8'h00;
    end else begin
      if (!mheld[i]) begin
        if (mkq[i] && marm[i]) begin
          ep[i] = 1'b1; mheld[i] = 1'b1; h[i] = 0; mcnt[i] = mcnt[i] + 8'h01;
        end
      end else begin
        h[i] = h[i] + 1;
        if (!mkq[i]) begin
          er[i] = 1'b1; mheld[i] = 1'b0;
        end else if (h[i] >= lc && ((h[i] - lc) % rc) == 0) begin
          ert[i] = 1'b1;
        end
      end
      el[i] = mheld[i] && (h[i] >= lc);
      if (!mkq[i]) marm[i] = 1'b1;
      mkq[i] = pk;
    end
  endtask

  task automatic cyc(input bit pa, input bit pb, input bit r);
    logic [11:0] ea, eb;
    kin_a = ~pa;
    kin_b = pb;
    rst   = r;
    @(posedge clk);
    model_step(0, pa, r);
    model_step(1, pb, r);
    #1;
    ea = {ep[0], er[0], ert[0], el[0], exp_cnt(0)};
    eb = {ep[1], er[1], ert[1], el[1], exp_cnt(1)};
    checks++;
    assert ({press_a, release_a, rept_a, long_a, cnt_a} === ea) else begin
      errors++;
      $error("FAIL dut_a t=%0t got=%h exp=%h", $time, {press_a, release_a, rept_a, long_a, cnt_a}, ea);
    end
    checks++;
    assert ({press_b, release_b, rept_b, long_b, cnt_b} === eb) else begin
      errors++;
      $error("FAIL dut_b t=%0t got=%h exp=%h", $time, {press_b, release_b, rept_b, long_b, cnt_b}, eb);
    end
  endtask

  // Key a held at a fixed level, key b toggles with random run lengths.
  task automatic hold(input bit pa, input int n);
    for (int k = 0; k < n; k++) begin
      if (bleft == 0) begin
        bgen  = ~bgen;
        bleft = $urandom_range(1, 30);
      end
      bleft--;
      cyc(pa, bgen, 1'b0);
    end
  endtask

  task automatic holdb(input bit pb, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, pb, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
    checks++;
    assert ({press_a, release_a, rept_a, long_a, cnt_a} === 12'h000) else begin
      errors++;
      $error("FAIL reset_a got=%h exp=%h", {press_a, release_a, rept_a, long_a, cnt_a}, 12'h000);
    end

    // Short press, then long hold through three repeats.
    hold(1'b0, 20); hold(1'b1, 50); hold(1'b0, 20);
    hold(1'b1, 1500); hold(1'b0, 10);

    // Key held during and after reset.
    hold(1'b1, 5);
    for (int k = 0; k < 3; k++) cyc(1'b1, bgen, 1'b1);
    hold(1'b1, 100); hold(1'b0, 5); hold(1'b1, 20); hold(1'b0, 10);

    // Reset while repeating.
    hold(1'b1, 1100);
    cyc(1'b1, bgen, 1'b1);
    checks++;
    assert ({press_a, release_a, rept_a, long_a} === 4'b0000) else begin
      errors++;
      $error("FAIL rst_mid_rpt got=%b exp=%b", {press_a, release_a, rept_a, long_a}, 4'b0000);
    end
    hold(1'b1, 50); hold(1'b0, 5); hold(1'b1, 10); hold(1'b0, 5);

    // Release-duration sweep around the first timer match on dut_b.
    holdb(1'b0, 5);
    for (int n = 6; n <= 16; n++) begin
      holdb(1'b1, n);
      holdb(1'b0, 2);
      if (n == 10) begin
        checks++;
        assert ({release_b, rept_b, long_b} === 3'b100) else begin
          errors++;
          $error("FAIL rel_at_match got=%b exp=%b", {release_b, rept_b, long_b}, 3'b100);
        end
      end
      holdb(1'b0, 3);
    end

    // 300 random-length short presses from reset.
    cyc(1'b0, bgen, 1'b1); cyc(1'b0, bgen, 1'b1);
    for (int k = 0; k < 300; k++) begin
      hold(1'b0, $urandom_range(1, 5));
      hold(1'b1, $urandom_range(1, 5));
    end
    hold(1'b0, 5);
    checks++;
`ifdef KEYEVT_CNT_EN
    assert (cnt_a === 8'd44) else begin
      errors++;
      $error("FAIL cnt_300 got=%0d exp=%0d", cnt_a, 44);
    end
`else
    assert (cnt_a === 8'd0) else begin
      errors++;
      $error("FAIL cnt_300 got=%0d exp=%0d", cnt_a, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Sits directly downstream of the key debouncer.
- Consumes the debounced key level and converts it into single-cycle event pulses: press, release and auto-repeat, plus a long-press status level.
- Feeds the CPU panel logic (single-step, register/address increment keys), so that one physical press yields exactly one action and a held key auto-repeats.

Parameters:
- LONG_CYC, 1000, hold duration in CLK cycles before the first repeat; legal range 2..65535.
- REP_CYC, 200, period in CLK cycles between subsequent repeats; legal range 2..65535.
- ACT_LOW, 1, key polarity. 1: KIN=0 means pressed (debouncer output for a pull-up key). 0: KIN=1 means pressed.

Ports:
- CLK  input  1  system clock; all logic on posedge CLK.
- RST  input  1  synchronous reset, active-high.
- KIN  input  1  debounced key level from the debouncer.
- PRESS  output  1  one-cycle pulse on each new press.
- RELEASE  output  1  one-cycle pulse on each release.
- REPT  output  1  one-cycle pulse at each auto-repeat point.
- LONG  output  1  level; high while the key is held past LONG_CYC.
- CNT  output  8  press counter (only with the optional feature; see below).

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high, sampled on posedge CLK.
- Reset values: PRESS=0, RELEASE=0, REPT=0, LONG=0, CNT=0, state=IDLE, timer=0.
- Input stage:
  - pk = ACT_LOW ? ~KIN : KIN, registered into k_q each edge.
  - k_q resets to the pressed value. A key already held at reset therefore produces no PRESS; a released sample must be seen first.
- Timer: 16-bit, counts held cycles, cleared on every state change. Comparisons use timer == LONG_CYC-1 and timer == REP_CYC-1.
- FSM states and transitions (evaluated each edge):
  - IDLE:
    - k_q pressed and armed: PRESS=1, timer=0, go HELD.
    - armed: set on any cycle k_q is released.
  - HELD:
    - k_q released: RELEASE=1, go IDLE.
    - else if timer==LONG_CYC-1: REPT=1, LONG=1, timer=0, go RPT.
    - else timer+1.
  - RPT:
    - k_q released: RELEASE=1, LONG=0, go IDLE.
    - else if timer==REP_CYC-1: REPT=1, timer=0.
    - else timer+1.
- Pulse outputs are registered and high for exactly one cycle. PRESS, RELEASE and REPT are mutually exclusive in any cycle.
- Latency: KIN becoming pressed before edge t gives k_q at edge t and PRESS high from edge t+1 to edge t+2. Release latency is identical.
- First REPT occurs LONG_CYC cycles after the PRESS cycle; subsequent REPTs every REP_CYC cycles.
- Boundary: release sampled on the same cycle as a timer match → release wins, no REPT.
- Boundary: timer can never wrap, because it is cleared at the match before reaching 2^16.
- Boundary: RST asserted in any state → all outputs 0 at the next edge, state IDLE, disarmed.
- Boundary: a glitch on KIN is not filtered here. Debouncing is the upstream block's job; every k_q transition is honoured.

Optional Feature:
- Macro: KEYEVT_CNT_EN.
- Defined: CNT is an 8-bit counter that increments on every PRESS pulse (REPT does not count). It wraps 255→0 and is cleared by RST.
- Undefined: the CNT port is still present but tied to 8'h00, and no counter flops are generated.

Test Plan:
- Short press: RST 3 cycles; KIN=1 for 20 cycles, 0 for 50, 1 (ACT_LOW=1) → exactly one PRESS 2 cycles after the fall; one RELEASE 2 cycles after the rise; REPT never; LONG stays 0.
- Long hold: LONG_CYC=1000, REP_CYC=200; KIN=0 for 1500 cycles → PRESS; REPT at 1000, 1200 and 1400 cycles after PRESS (3 pulses); LONG=1 from the first REPT until the cycle after RELEASE.
- Held through reset: KIN=0 during and after RST for 100 cycles → no PRESS. Then KIN=1 for 5 cycles, 0 again → one PRESS.
- Reset mid-repeat: during RPT with LONG=1, assert RST 1 cycle → LONG=0 and pulses 0 at the next edge. Key still held afterwards → no PRESS until released and re-pressed.
- Release at match: LONG_CYC=10; release timed so k_q goes released on the timer==9 cycle → RELEASE=1, REPT=0, LONG=0.
- Counter (KEYEVT_CNT_EN defined): 300 short presses → CNT=44. Without the macro → CNT=0 throughout.
